mono_bbox_overlay: RTL and testbench



---
 rtl/vp_pkg.sv | 18 +
 rtl/bbox_accum.sv | 83 ++++++++
 rtl/mono_bbox_overlay.sv | 149 ++++++++++++++
 tb/tb_mono_bbox_overlay.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// Shared video-pipeline definitions: default geometry widths, palette and
// the frame-statistics FSM encoding.
package vp_pkg;

  localparam int X_W_DEF = 11;
  localparam int Y_W_DEF = 10;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] RED   = 24'hFF0000;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    ACCUM     = 2'd1,
    LATCH     = 2'd2
  } bbox_state_t;

endpackage

// File: rtl/bbox_accum.sv
// Pixel position counters plus the running min/max/count of white pixels
// for the frame currently being received.
module bbox_accum
  import vp_pkg::*;
#(
  parameter int X_W   = X_W_DEF,
  parameter int Y_W   = Y_W_DEF,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_de,
  input  logic             i_pix,
  input  logic             i_vs_rise,
  input  logic             i_init,
  input  logic             i_en,
  output logic [X_W-1:0]   o_x,
  output logic [Y_W-1:0]   o_y,
  output logic [X_W-1:0]   o_min_x,
  output logic [X_W-1:0]   o_max_x,
  output logic [Y_W-1:0]   o_min_y,
  output logic [Y_W-1:0]   o_max_y,
  output logic [CNT_W-1:0] o_count
);

  logic             r_de_d;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [X_W-1:0]   r_min_x;
  logic [X_W-1:0]   r_max_x;
  logic [Y_W-1:0]   r_min_y;
  logic [Y_W-1:0]   r_max_y;
  logic [CNT_W-1:0] r_count;
  logic             w_de_fall;

  assign w_de_fall = r_de_d & ~i_de;

  // Both counters saturate instead of wrapping so oversized lines/frames clamp.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_de_d <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
    end else begin
      r_de_d <= i_de;
      if (i_de) begin
        if (r_x != '1) r_x <= r_x + 1'b1;
      end else if (w_de_fall) begin
        r_x <= '0;
      end
      if (i_vs_rise) begin
        r_y <= '0;
      end else if (w_de_fall && (r_y != '1)) begin
        r_y <= r_y + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_init) begin
      r_min_x <= '1;
      r_max_x <= '0;
      r_min_y <= '1;
      r_max_y <= '0;
      r_count <= '0;
    end else if (i_en && i_de && i_pix) begin
      if (r_x < r_min_x) r_min_x <= r_x;
      if (r_x > r_max_x) r_max_x <= r_x;
      if (r_y < r_min_y) r_min_y <= r_y;
      if (r_y > r_max_y) r_max_y <= r_y;
      if (r_count != '1) r_count <= r_count + 1'b1;
    end
  end

  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_min_x = r_min_x;
  assign o_max_x = r_max_x;
  assign o_min_y = r_min_y;
  assign o_max_y = r_max_y;
  assign o_count = r_count;

endmodule

// File: rtl/mono_bbox_overlay.sv
// Tracks the white-pixel bounding box of each mono frame, publishes it at the
// next vsync and draws the published box as an outline on the RGB output.
module mono_bbox_overlay
  import vp_pkg::*;
#(
  parameter int          X_W       = X_W_DEF,
  parameter int          Y_W       = Y_W_DEF,
  parameter int          CNT_W     = 20,
  parameter int          MIN_PIX   = 64,
  parameter logic [23:0] BOX_COLOR = RED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pre_frame_vsync,
  input  logic             pre_frame_hsync,
  input  logic             pre_frame_de,
  input  logic             monoc,
  output logic             post_frame_vsync,
  output logic             post_frame_hsync,
  output logic             post_frame_de,
  output logic [23:0]      post_rgb,
  output logic [X_W-1:0]   box_left,
  output logic [X_W-1:0]   box_right,
  output logic [Y_W-1:0]   box_top,
  output logic [Y_W-1:0]   box_bottom,
  output logic [CNT_W-1:0] box_count,
  output logic             box_valid,
  output logic             frame_done
);

  bbox_state_t      r_state, w_next_state;
  logic             r_vs_d, r_vs_rise;
  logic             w_vs_rise, w_latch, w_accum_en;
  logic [X_W-1:0]   w_x, w_min_x, w_max_x;
  logic [Y_W-1:0]   w_y, w_min_y, w_max_y;
  logic [CNT_W-1:0] w_count;
  logic [X_W-1:0]   r_box_left, r_box_right;
  logic [Y_W-1:0]   r_box_top, r_box_bottom;
  logic [CNT_W-1:0] r_box_count;
  logic             r_box_valid, r_frame_done;
  logic             r_post_vs, r_post_hs, r_post_de;
  logic [23:0]      r_post_rgb, w_rgb;
  logic             w_on_col, w_on_row, w_border;

  assign w_vs_rise = pre_frame_vsync & ~r_vs_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_d    <= 1'b0;
      r_vs_rise <= 1'b0;
      r_state   <= WAIT_SYNC;
    end else begin
      r_vs_d    <= pre_frame_vsync;
      r_vs_rise <= w_vs_rise;
      r_state   <= w_next_state;
    end
  end

  // The first vsync after reset only arms accumulation, discarding the partial frame.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WAIT_SYNC: if (r_vs_rise) w_next_state = ACCUM;
      ACCUM:     if (r_vs_rise) w_next_state = LATCH;
      LATCH:     w_next_state = ACCUM;
      default:   w_next_state = WAIT_SYNC;
    endcase
  end

  always_comb begin
    w_latch    = (r_state == LATCH);
    w_accum_en = (r_state == ACCUM) && !w_vs_rise;
  end

  bbox_accum #(.X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W)) u_accum (
    .clk       (clk),
    .rst       (rst),
    .i_de      (pre_frame_de),
    .i_pix     (monoc),
    .i_vs_rise (w_vs_rise),
    .i_init    (w_latch),
    .i_en      (w_accum_en),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_min_x   (w_min_x),
    .o_max_x   (w_max_x),
    .o_min_y   (w_min_y),
    .o_max_y   (w_max_y),
    .o_count   (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_box_left   <= '0;
      r_box_right  <= '0;
      r_box_top    <= '0;
      r_box_bottom <= '0;
      r_box_count  <= '0;
      r_box_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_latch;
      if (w_latch) begin
        r_box_left   <= w_min_x;
        r_box_right  <= w_max_x;
        r_box_top    <= w_min_y;
        r_box_bottom <= w_max_y;
        r_box_count  <= w_count;
        r_box_valid  <= (w_count >= CNT_W'(MIN_PIX));
      end
    end
  end

  always_comb begin
    w_on_col = ((w_x == r_box_left) || (w_x == r_box_right)) &&
               (w_y >= r_box_top) && (w_y <= r_box_bottom);
    w_on_row = ((w_y == r_box_top) || (w_y == r_box_bottom)) &&
               (w_x >= r_box_left) && (w_x <= r_box_right);
    w_border = w_on_col || w_on_row;
    w_rgb    = (r_box_valid && w_border) ? BOX_COLOR : (monoc ? WHITE : BLACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_post_vs  <= 1'b0;
      r_post_hs  <= 1'b0;
      r_post_de  <= 1'b0;
      r_post_rgb <= '0;
    end else begin
      r_post_vs  <= pre_frame_vsync;
      r_post_hs  <= pre_frame_hsync;
      r_post_de  <= pre_frame_de;
      r_post_rgb <= pre_frame_de ? w_rgb : BLACK;
    end
  end

  assign post_frame_vsync = r_post_vs;
  assign post_frame_hsync = r_post_hs;
  assign post_frame_de    = r_post_de;
  assign post_rgb         = r_post_rgb;
  assign box_left         = r_box_left;
  assign box_right        = r_box_right;
  assign box_top          = r_box_top;
  assign box_bottom       = r_box_bottom;
  assign box_count        = r_box_count;
  assign box_valid        = r_box_valid;
  assign frame_done       = r_frame_done;

endmodule

// File: tb/tb_mono_bbox_overlay.sv
// Scoreboard bench for mono_bbox_overlay: drives 64x48 mono frames and checks
// the delayed RGB stream and the published bounding box every cycle.
module tb_mono_bbox_overlay;

  localparam int X_W = 11;
  localparam int Y_W = 10;
  localparam int CNT_W = 20;
  localparam int MIN_PIX = 64;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam int COLS = 64;
  localparam int ROWS = 48;
  localparam int LONG_W = 2100;
  localparam int M_SQ = 0, M_FIFTY = 1, M_BLACK = 2, M_LONG = 3;

  logic clk = 1'b0;
  logic rst, vs, hs, de, mono;
  logic pvs, phs, pde, bv, fd;
  logic [23:0] prgb;
  logic [X_W-1:0] bl, br;
  logic [Y_W-1:0] bt, bb;
  logic [CNT_W-1:0] bc;

  mono_bbox_overlay #(.X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W), .MIN_PIX(MIN_PIX),
                      .BOX_COLOR(RED)) dut (
    .clk              (clk),
    .rst              (rst),
    .pre_frame_vsync  (vs),
    .pre_frame_hsync  (hs),
    .pre_frame_de     (de),
    .monoc            (mono),
    .post_frame_vsync (pvs),
    .post_frame_hsync (phs),
    .post_frame_de    (pde),
    .post_rgb         (prgb),
    .box_left         (bl),
    .box_right        (br),
    .box_top          (bt),
    .box_bottom       (bb),
    .box_count        (bc),
    .box_valid        (bv),
    .frame_done       (fd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] l;
    logic [10:0] r;
    logic [9:0]  t;
    logic [9:0]  b;
    logic [19:0] c;
    logic        v;
  } box_t;

  typedef struct {
    int   due;
    box_t box;
  } fexp_t;

  typedef struct {
    logic        vs, hs, de;
    logic [23:0] rgb;
    int          x, y;
  } pexp_t;

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;
  int lastY = 0;
  bit started = 0;
  bit running = 0;
  logic prevVs = 1'b0;
  fexp_t boxQ[$];
  pexp_t streamQ[$];
  box_t dispBox;
  box_t acc;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic box_t initAcc();
    box_t a;
    a.l = '1; a.r = '0; a.t = '1; a.b = '0; a.c = '0; a.v = 1'b0;
    return a;
  endfunction

  function automatic logic [23:0] pixColor(input logic m, input int x, input int y);
    bit onBorder;
    onBorder = ((x == int'(dispBox.l) || x == int'(dispBox.r)) &&
                y >= int'(dispBox.t) && y <= int'(dispBox.b)) ||
               ((y == int'(dispBox.t) || y == int'(dispBox.b)) &&
                x >= int'(dispBox.l) && x <= int'(dispBox.r));
    if (dispBox.v && onBorder) return RED;
    return m ? WHITE : 24'h000000;
  endfunction

  function automatic logic isWhite(input int mode, input int col, input int row);
    case (mode)
      M_SQ:    return (col >= 10 && col <= 19 && row >= 5 && row <= 14);
      M_FIFTY: return (col >= 10 && col <= 19 && row >= 5 && row <= 9);
      M_LONG:  return (row == 0 && col == LONG_W - 1);
      default: return 1'b0;
    endcase
  endfunction

  // Compare what the DUT shows now against what was predicted one cycle earlier.
  task automatic doChecks();
    pexp_t p;
    fexp_t f;
    logic expFd;
    if (streamQ.size() > 0) begin
      p = streamQ.pop_front();
      checkOutput("sync", {61'd0, pvs, phs, pde}, {61'd0, p.vs, p.hs, p.de});
      checkOutput($sformatf("rgb(%0d,%0d)", p.x, p.y), {40'd0, prgb}, {40'd0, p.rgb});
    end
    expFd = 1'b0;
    if (boxQ.size() > 0 && boxQ[0].due == cyc) begin
      f = boxQ.pop_front();
      dispBox = f.box;
      expFd = 1'b1;
    end
    checkOutput("frame_done", {63'd0, fd}, {63'd0, expFd});
    checkOutput(expFd ? "box_latched" : "box_hold", {1'b0, bl, br, bt, bb, bc, bv}, {1'b0, dispBox});
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic h, input logic d,
                               input logic m, input int x, input int y);
    pexp_t p;
    fexp_t f;
    @(negedge clk);
    cyc++;
    if (started) doChecks();
    rst = r; vs = v; hs = h; de = d; mono = m;
    started = 1;
    p.x = x; p.y = y;
    if (r) begin
      p.vs = 1'b0; p.hs = 1'b0; p.de = 1'b0; p.rgb = '0;
      boxQ.delete();
      dispBox = '0;
      running = 0;
      acc = initAcc();
    end else begin
      p.vs = v; p.hs = h; p.de = d;
      p.rgb = d ? pixColor(m, x, y) : 24'h000000;
      if (v && !prevVs) begin
        if (running) begin
          f.due = cyc + 3;
          f.box = acc;
          f.box.v = (acc.c >= 20'(MIN_PIX));
          boxQ.push_back(f);
        end
        running = 1;
        acc = initAcc();
      end else if (running && d && m) begin
        if (x < int'(acc.l)) acc.l = 11'(x);
        if (x > int'(acc.r)) acc.r = 11'(x);
        if (y < int'(acc.t)) acc.t = 10'(y);
        if (y > int'(acc.b)) acc.b = 10'(y);
        acc.c = acc.c + 1'b1;
      end
    end
    prevVs = r ? 1'b0 : v;
    streamQ.push_back(p);
  endtask

  task automatic sendFrame(input int mode, input int rstRow, input bit stray, input int yOff);
    int w;
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, stray && (i == 0), stray && (i == 0), 0, lastY);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int row = 0; row < ROWS; row++) begin
      w = (mode == M_LONG && row == 0) ? LONG_W : COLS;
      if (row == rstRow) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      for (int col = 0; col < w; col++)
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, isWhite(mode, col, row),
                      (col > 2047) ? 2047 : col, row + yOff);
      for (int i = 0; i < 6; i++)
        applyStimulus(1'b0, 1'b0, (i >= 1 && i < 3), 1'b0, 1'b0, 0, 0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    lastY = ROWS + yOff;
  endtask

  initial begin
    rst = 1'b1; vs = 1'b0; hs = 1'b0; de = 1'b0; mono = 1'b0;
    dispBox = '0;
    acc = initAcc();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    $display("[TB] three square frames");
    sendFrame(M_SQ, -1, 0, 0);
    sendFrame(M_SQ, -1, 0, 0);
    sendFrame(M_SQ, -1, 0, 0);
    $display("[TB] below-threshold, black and square frames");
    sendFrame(M_FIFTY, -1, 0, 0);
    sendFrame(M_BLACK, -1, 0, 0);
    sendFrame(M_SQ, -1, 0, 0);
    $display("[TB] reset at line 20");
    sendFrame(M_SQ, 20, 0, 0);
    sendFrame(M_SQ, -1, 0, 0);
    $display("[TB] pixel on vsync edge, then saturating long line");
    sendFrame(M_SQ, -1, 1, 1);
    sendFrame(M_LONG, -1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
